// File: rtl/iagc_amp_frame_packer_pkg.sv
// iagc_amp_frame_packer_pkg: sync byte, IAGC status codes and frame FSM encoding.
// IAGC_AMP_FRAME_CHECKSUM_EN adds the trailing checksum state.
package iagc_amp_frame_packer_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [3:0] IAGC_ST_IDLE = 4'h0;
    localparam logic [3:0] IAGC_ST_CAL = 4'h1;
    localparam logic [3:0] IAGC_ST_ARMED = 4'h2;
    localparam logic [3:0] IAGC_ST_RUN = 4'h3;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_CH_ID,
        ST_AMP
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
        , ST_CSUM
`endif
    } frame_state_e;
    function automatic int amp_bytes(input int amp_width);
        return (amp_width + 7) / 8;
    endfunction
endpackage

// File: rtl/iagc_amp_frame_packer_if.sv
// iagc_amp_frame_packer_if: valid/ready byte stream from the frame packer into the UART.
interface iagc_amp_frame_packer_if;
    logic [7:0] o_byte;
    logic       o_byteValid;
    logic       i_byteReady;
    modport master(output o_byte, output o_byteValid, input i_byteReady);
    modport slave(input o_byte, input o_byteValid, output i_byteReady);
endinterface

// File: rtl/iagc_frame_serializer.sv
// iagc_frame_serializer: amplitude snapshot buffer and byte-framing TX FSM.
// IAGC_AMP_FRAME_CHECKSUM_EN appends an XOR checksum of seq..last amp byte.
module iagc_frame_serializer
    import iagc_amp_frame_packer_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int AMP_WIDTH = 15
) (
    input  logic                              i_clock,
    input  logic                              i_nReset,
    input  logic                              i_load,
    input  logic [NUM_CHANNELS*AMP_WIDTH-1:0] i_amps,
    output logic                              o_idle,
    iagc_amp_frame_packer_if.master           io_tx
);
    localparam int AB = amp_bytes(AMP_WIDTH);
    localparam int AB8 = AB * 8;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int BW = AB > 1 ? $clog2(AB) : 1;
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
    localparam frame_state_e ST_AFTER_AMP = ST_CSUM;
    logic [7:0] r_csum;
`else
    localparam frame_state_e ST_AFTER_AMP = ST_IDLE;
`endif
    frame_state_e r_state, w_next;
    logic [7:0] r_seq, w_byte;
    logic [CW-1:0] r_ch;
    logic [BW-1:0] r_beat;
    logic [NUM_CHANNELS*AMP_WIDTH-1:0] r_buf;
    logic [AB8-1:0] w_amp;
    logic w_hs, w_last_beat, w_last_ch;

    assign w_hs = io_tx.o_byteValid && io_tx.i_byteReady;
    assign w_amp = AB8'(r_buf[r_ch*AMP_WIDTH +: AMP_WIDTH]);
    assign w_last_beat = r_beat == BW'(AB - 1);
    assign w_last_ch = r_ch == CW'(NUM_CHANNELS - 1);
    assign o_idle = r_state == ST_IDLE;
    assign io_tx.o_byteValid = r_state != ST_IDLE;
    assign io_tx.o_byte = w_byte;

    always_comb begin
        w_next = r_state;
        w_byte = 8'h00;
        case (r_state)
            ST_IDLE: w_next = i_load ? ST_SYNC : ST_IDLE;
            ST_SYNC: begin
                w_byte = SYNC_BYTE;
                w_next = w_hs ? ST_SEQ : ST_SYNC;
            end
            ST_SEQ: begin
                w_byte = r_seq;
                w_next = w_hs ? ST_CH_ID : ST_SEQ;
            end
            ST_CH_ID: begin
                w_byte = 8'(r_ch);
                w_next = w_hs ? ST_AMP : ST_CH_ID;
            end
            ST_AMP: begin
                w_byte = w_amp[8*(AB-1-int'(r_beat)) +: 8];
                if (w_hs && w_last_beat) w_next = w_last_ch ? ST_AFTER_AMP : ST_CH_ID;
            end
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
            ST_CSUM: begin
                w_byte = r_csum;
                w_next = w_hs ? ST_IDLE : ST_CSUM;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state <= ST_IDLE;
            r_seq <= '0;
            r_ch <= '0;
            r_beat <= '0;
            r_buf <= '0;
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
            r_csum <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (o_idle && i_load) begin
                r_buf <= i_amps;
                r_ch <= '0;
                r_beat <= '0;
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
                r_csum <= '0;
`endif
            end
            if (w_hs) begin
                if (r_state == ST_CH_ID) r_beat <= '0;
                if (r_state == ST_AMP) r_beat <= r_beat + 1'b1;
                if (r_state == ST_AMP && w_last_beat) r_ch <= r_ch + 1'b1;
                if (w_next == ST_IDLE) r_seq <= r_seq + 8'd1;
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
                if (r_state != ST_SYNC) r_csum <= r_csum ^ w_byte;
`endif
            end
        end
    end
endmodule

// File: rtl/iagc_amp_frame_packer.sv
// iagc_amp_frame_packer: per-channel peak-to-peak amplitude over a sample window, framed to UART.
// IAGC_AMP_FRAME_CHECKSUM_EN (in iagc_frame_serializer) appends a checksum byte.
module iagc_amp_frame_packer
    import iagc_amp_frame_packer_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 14,
    parameter int WINDOW_SAMPLES = 1000,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter logic [IAGC_STATUS_SIZE-1:0] RUN_STATUS = IAGC_STATUS_SIZE'(IAGC_ST_RUN),
    localparam int AMP_WIDTH = SAMPLE_WIDTH + 1
) (
    input  logic                                 i_clock,
    input  logic                                 i_nReset,
    input  logic [IAGC_STATUS_SIZE-1:0]          i_iagcStatus,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
    input  logic                                 i_valid,
    output logic [NUM_CHANNELS*AMP_WIDTH-1:0]    o_amplitudes,
    output logic                                 o_ampValid,
    output logic                                 o_overrun,
    iagc_amp_frame_packer_if.master              io_tx
);
    localparam int CNT_W = $clog2(WINDOW_SAMPLES);
    localparam logic signed [SAMPLE_WIDTH-1:0] S_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] S_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    logic signed [SAMPLE_WIDTH-1:0] r_max [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] r_min [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] w_s [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] w_max [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] w_min [NUM_CHANNELS];
    logic [NUM_CHANNELS*AMP_WIDTH-1:0] w_amps;
    logic [CNT_W-1:0] r_cnt;
    logic w_run, w_end, w_idle;

    assign w_run = i_iagcStatus == RUN_STATUS;
    assign w_end = w_run && i_valid && r_cnt == CNT_W'(WINDOW_SAMPLES - 1);

    // amplitude includes the sample arriving on the window-end cycle
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign w_s[c] = i_samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign w_max[c] = w_s[c] > r_max[c] ? w_s[c] : r_max[c];
        assign w_min[c] = w_s[c] < r_min[c] ? w_s[c] : r_min[c];
        assign w_amps[c*AMP_WIDTH +: AMP_WIDTH] = {w_max[c][SAMPLE_WIDTH-1], w_max[c]} - {w_min[c][SAMPLE_WIDTH-1], w_min[c]};
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_cnt <= '0;
            o_amplitudes <= '0;
            o_ampValid <= 1'b0;
            o_overrun <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_max[c] <= S_MIN;
                r_min[c] <= S_MAX;
            end
        end else begin
            o_ampValid <= w_end;
            if (w_end) o_amplitudes <= w_amps;
            if (!w_run) begin
                r_cnt <= '0;
                o_overrun <= 1'b0;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_max[c] <= S_MIN;
                    r_min[c] <= S_MAX;
                end
            end else if (i_valid) begin
                r_cnt <= w_end ? '0 : r_cnt + 1'b1;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_max[c] <= w_end ? S_MIN : w_max[c];
                    r_min[c] <= w_end ? S_MAX : w_min[c];
                end
            end
            if (w_end && !w_idle) o_overrun <= 1'b1;
        end
    end

    iagc_frame_serializer #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .AMP_WIDTH(AMP_WIDTH)
    ) u_ser (
        .i_clock(i_clock),
        .i_nReset(i_nReset),
        .i_load(w_end),
        .i_amps(w_amps),
        .o_idle(w_idle),
        .io_tx(io_tx)
    );
endmodule

// File: tb/tb_iagc_amp_frame_packer.sv
// tb_iagc_amp_frame_packer: directed scenarios plus random traffic checked against a window/frame model.
module tb_iagc_amp_frame_packer;
    localparam int N = 2;
    localparam int SW = 14;
    localparam int W = 4;
    localparam int AW = 15;
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic [3:0] status = 4'h3;
    logic [N*SW-1:0] samples = '0;
    logic [N*AW-1:0] amps;
    logic amp_valid, overrun;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] got[$];

    iagc_amp_frame_packer_if bus();

    iagc_amp_frame_packer #(
        .NUM_CHANNELS(N), .SAMPLE_WIDTH(SW), .WINDOW_SAMPLES(W),
        .IAGC_STATUS_SIZE(4), .RUN_STATUS(4'h3)
    ) dut (
        .i_clock(clk), .i_nReset(rst_n), .i_iagcStatus(status), .i_samples(samples),
        .i_valid(valid), .o_amplitudes(amps), .o_ampValid(amp_valid), .o_overrun(overrun),
        .io_tx(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: windows as plain sample lists, frames as byte queues
    logic [7:0] exp_q[$];
    int seq_m, cnt_m, mx, mn;
    int win[N][W];
    int amp_m[N];
    logic [N*AW-1:0] exp_amps;
    logic exp_av, exp_ovr, busy_m, hs_m, start_m;
    logic [7:0] x_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            seq_m = 0;
            cnt_m = 0;
            exp_amps = '0;
            exp_av = 1'b0;
            exp_ovr = 1'b0;
        end else begin
            busy_m = exp_q.size() > 0;
            hs_m = busy_m && bus.i_byteReady;
            start_m = 1'b0;
            exp_av = 1'b0;
            if (status != 4'h3) begin
                cnt_m = 0;
                exp_ovr = 1'b0;
            end else if (valid) begin
                for (int c = 0; c < N; c++) win[c][cnt_m] = int'($signed(samples[c*SW +: SW]));
                cnt_m++;
                if (cnt_m == W) begin
                    cnt_m = 0;
                    exp_av = 1'b1;
                    for (int c = 0; c < N; c++) begin
                        mx = -100000;
                        mn = 100000;
                        for (int i = 0; i < W; i++) begin
                            if (win[c][i] > mx) mx = win[c][i];
                            if (win[c][i] < mn) mn = win[c][i];
                        end
                        amp_m[c] = mx - mn;
                        exp_amps[c*AW +: AW] = AW'(amp_m[c]);
                    end
                    if (busy_m) exp_ovr = 1'b1;
                    else start_m = 1'b1;
                end
            end
            if (hs_m) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) seq_m = (seq_m + 1) % 256;
            end
            if (start_m) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'(seq_m));
                for (int c = 0; c < N; c++) begin
                    exp_q.push_back(8'(c));
                    exp_q.push_back(8'(amp_m[c] / 256));
                    exp_q.push_back(8'(amp_m[c] % 256));
                end
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
                x_m = 8'h00;
                for (int i = 1; i < exp_q.size(); i++) x_m = x_m ^ exp_q[i];
                exp_q.push_back(x_m);
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("byteValid", 32'(bus.o_byteValid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("byte", 32'(bus.o_byte), 32'(exp_q[0]));
        check("amplitudes", 32'(amps), 32'(exp_amps));
        check("ampValid", 32'(amp_valid), 32'(exp_av));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        if (rst_n && bus.o_byteValid && bus.i_byteReady) got.push_back(bus.o_byte);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_win(input int a[4], input int b[4]);
        for (int i = 0; i < 4; i++) begin
            samples = {SW'(b[i]), SW'(a[i])};
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (got.size() < n && k < 200) begin
            tick();
            k++;
        end
        check("wait_bytes", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic check_got(input string nm, input logic [7:0] e[8], input logic [7:0] cs);
        for (int i = 0; i < 8; i++) check(nm, 32'(got[i]), 32'(e[i]));
`ifdef IAGC_AMP_FRAME_CHECKSUM_EN
        check({nm, "_csum"}, 32'(got[8]), 32'(cs));
`endif
    endtask

    initial begin
        bus.i_byteReady = 1'b1;
        tick();
        check("rst_amps", 32'(amps), 32'd0);
        check("rst_ampValid", 32'(amp_valid), 32'd0);
        check("rst_byteValid", 32'(bus.o_byteValid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        // 1: basic frame
        got.delete();
        send_win('{-5, 3, 10, -2}, '{7, 7, 7, 7});
        check("t1_ampValid", 32'(amp_valid), 32'd1);
        check("t1_amps", 32'(amps), 32'd15);
        wait_bytes(FLEN);
        check_got("t1_frame", '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h00, 8'h00}, 8'h0E);
        // 2: stall on byte 3
        tick();
        got.delete();
        send_win('{-5, 3, 10, -2}, '{7, 7, 7, 7});
        wait_bytes(3);
        bus.i_byteReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_byte", 32'(bus.o_byte), 32'h00);
            check("t2_hold_valid", 32'(bus.o_byteValid), 32'd1);
            tick();
        end
        bus.i_byteReady = 1'b1;
        wait_bytes(FLEN);
        check_got("t2_frame", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h00, 8'h00}, 8'h0F);
        // 3: overrun while stalled
        tick();
        got.delete();
        bus.i_byteReady = 1'b0;
        send_win('{1, 2, 3, 4}, '{0, 0, 0, 0});
        send_win('{9, 9, 9, 9}, '{0, 0, 0, 0});
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_byte", 32'(bus.o_byte), 32'hA5);
        bus.i_byteReady = 1'b1;
        wait_bytes(FLEN);
        repeat (20) tick();
        check("t3_one_frame", 32'(got.size()), 32'(FLEN));
        check("t3_seq", 32'(got[1]), 32'h02);
        // 4: status leaves run mid-window
        samples = {SW'(0), SW'(100)};
        valid = 1'b1;
        tick();
        samples = {SW'(0), SW'(-100)};
        tick();
        valid = 1'b0;
        status = 4'h1;
        repeat (3) tick();
        check("t4_overrun_clr", 32'(overrun), 32'd0);
        status = 4'h3;
        send_win('{1, 2, 3, 4}, '{5, 5, 5, 5});
        check("t4_amps", 32'(amps), 32'd3);
        check("t4_ampValid", 32'(amp_valid), 32'd1);
        repeat (15) tick();
        // 5: full scale
        got.delete();
        send_win('{-8192, 8191, 0, 0}, '{0, 0, 0, 0});
        wait_bytes(FLEN);
        check("t5_id", 32'(got[2]), 32'h00);
        check("t5_msb", 32'(got[3]), 32'h3F);
        check("t5_lsb", 32'(got[4]), 32'hFF);
        repeat (3) tick();
        // 6: reset during amp byte
        got.delete();
        send_win('{1, 2, 3, 4}, '{0, 0, 0, 0});
        wait_bytes(4);
        rst_n = 1'b0;
        #1;
        check("t6_abort", 32'(bus.o_byteValid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        send_win('{1, 2, 3, 4}, '{0, 0, 0, 0});
        wait_bytes(2);
        check("t6_seq", 32'(got[1]), 32'h00);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            valid = $urandom_range(0, 1) == 1;
            samples = {SW'($urandom_range(0, 16383)), SW'($urandom_range(0, 16383))};
            bus.i_byteReady = $urandom_range(0, 3) != 0;
            status = $urandom_range(0, 29) == 0 ? 4'h1 : 4'h3;
            tick();
        end
        valid = 1'b0;
        status = 4'h3;
        bus.i_byteReady = 1'b1;
        repeat (30) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
